// File: rtl/trainer_sample_driver.sv
`default_nettype none
// ============================================================================
// Module   : trainer_sample_driver
// Purpose  : Host-side sample feeder for the online training engine. Buffers
//            host pixel streams into a ping-pong sample buffer and serves the
//            engine read port. Sequences start/train/expected_out, returns a
//            per-sample result record and tracks sliding-window accuracy.
// Revision : 1.0 - initial release
// ============================================================================
module trainer_sample_driver #(
  parameter int SAMPLE_LEN = 784,
  parameter int PIX_W      = 16,
  parameter int ADDR_W     = 10,
  parameter int IDX_W      = 8,
  parameter int WINDOW     = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_last,
  input  logic [IDX_W-1:0]  s_label,
  input  logic              s_train,
  output logic              eng_start,
  output logic              eng_train,
  input  logic              eng_done,
  input  logic [IDX_W-1:0]  eng_output_idx,
  output logic [IDX_W-1:0]  expected_out,
  input  logic [ADDR_W-1:0] mem_address,
  output logic [PIX_W-1:0]  mem_input,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [IDX_W-1:0]  r_pred,
  output logic [IDX_W-1:0]  r_label,
  output logic              r_correct,
  output logic [8:0]        window_correct,
  output logic [31:0]       sample_count,
  output logic              err_len
);

  localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(SAMPLE_LEN - 1);
  localparam logic [ADDR_W-1:0] c_len      = ADDR_W'(SAMPLE_LEN);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  state_t              r_state;
  logic [PIX_W-1:0]    r_mem [2][SAMPLE_LEN];
  logic [1:0]          r_full;
  logic [IDX_W-1:0]    r_lbl [2];
  logic [1:0]          r_trn;
  logic                r_fill_bank;
  logic                r_run_bank;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic                r_alive;
  logic [WINDOW-1:0]   r_hist;

  logic w_accept;
  logic w_at_end;
  logic w_close;
  logic w_drain_exit;
  logic w_correct_new;

  // s_ready is held low through reset and rises the first cycle after release
  assign s_ready       = r_alive & ~r_full[r_fill_bank];
  assign w_accept      = s_valid & s_ready;
  assign w_at_end      = (r_wr_ptr == c_last_ptr);
  assign w_close       = w_accept & (s_last | w_at_end);
  assign w_drain_exit  = (r_state == ST_DRAIN) & ~eng_done;
  assign w_correct_new = (eng_output_idx == r_lbl[r_run_bank]);

  // Pixel storage; unwritten locations keep stale data, so no reset here
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_mem[r_fill_bank][r_wr_ptr] <= s_data;
    end
  end

  // Engine read port: out-of-range addresses read as zero
  always_comb begin
    mem_input = '0;
    if (mem_address < c_len) begin
      mem_input = r_mem[r_run_bank][mem_address];
    end
  end

  // Label of the active bank is only presented while a run is in flight
  always_comb begin
    expected_out = '0;
    if (r_state != ST_IDLE) begin
      expected_out = r_lbl[r_run_bank];
    end
  end

  // Write side: fill pointer, bank flags, stored label/train and length error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_alive     <= 1'b0;
      r_wr_ptr    <= '0;
      r_fill_bank <= 1'b0;
      r_full      <= 2'b00;
      r_lbl[0]    <= '0;
      r_lbl[1]    <= '0;
      r_trn       <= 2'b00;
      err_len     <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      // Freeing the run bank and closing the fill bank never target the
      // same bank: a full bank deasserts s_ready.
      if (w_drain_exit) begin
        r_full[r_run_bank] <= 1'b0;
      end
      if (w_accept) begin
        if (s_last != w_at_end) begin
          err_len <= 1'b1;
        end
        if (w_close) begin
          r_full[r_fill_bank] <= 1'b1;
          r_lbl[r_fill_bank]  <= s_label;
          r_trn[r_fill_bank]  <= s_train;
          r_fill_bank         <= ~r_fill_bank;
          r_wr_ptr            <= '0;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end
    end
  end

  // Run sequencer with registered engine controls, result record and stats
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_run_bank     <= 1'b0;
      eng_start      <= 1'b0;
      eng_train      <= 1'b0;
      r_valid        <= 1'b0;
      r_pred         <= '0;
      r_label        <= '0;
      r_correct      <= 1'b0;
      r_hist         <= '0;
      window_correct <= '0;
      sample_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable && r_full[r_run_bank]) begin
            eng_start <= 1'b1;
            eng_train <= r_trn[r_run_bank];
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          eng_start <= 1'b0;
          r_state   <= ST_RUN;
        end
        ST_RUN: begin
          if (eng_done) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Wait out the multi-cycle done pulse before capturing the result
          if (!eng_done) begin
            r_pred         <= eng_output_idx;
            r_label        <= r_lbl[r_run_bank];
            r_correct      <= w_correct_new;
            r_valid        <= 1'b1;
            eng_train      <= 1'b0;
            r_run_bank     <= ~r_run_bank;
            r_hist         <= {r_hist[WINDOW-2:0], w_correct_new};
            window_correct <= window_correct + 9'(w_correct_new)
                              - 9'(r_hist[WINDOW-1]);
            sample_count   <= (&sample_count) ? sample_count
                                              : sample_count + 32'd1;
            r_state        <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trainer_sample_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_trainer_sample_driver
// Purpose  : Directed self-checking bench for trainer_sample_driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trainer_sample_driver;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic [7:0]  s_label = '0;
  logic        s_train = 1'b0;
  logic        eng_start;
  logic        eng_train;
  logic        eng_done = 1'b0;
  logic [7:0]  eng_output_idx = '0;
  logic [7:0]  expected_out;
  logic [9:0]  mem_address = '0;
  logic [15:0] mem_input;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [7:0]  r_pred;
  logic [7:0]  r_label;
  logic        r_correct;
  logic [8:0]  window_correct;
  logic [31:0] sample_count;
  logic        err_len;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] exp_data;
  } rd_vec_t;

  rd_vec_t rd_tab[6];

  trainer_sample_driver dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .s_label        (s_label),
    .s_train        (s_train),
    .eng_start      (eng_start),
    .eng_train      (eng_train),
    .eng_done       (eng_done),
    .eng_output_idx (eng_output_idx),
    .expected_out   (expected_out),
    .mem_address    (mem_address),
    .mem_input      (mem_input),
    .r_valid        (r_valid),
    .r_ready        (r_ready),
    .r_pred         (r_pred),
    .r_label        (r_label),
    .r_correct      (r_correct),
    .window_correct (window_correct),
    .sample_count   (sample_count),
    .err_len        (err_len)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic send_sample(input int n, input logic [7:0] lbl, input logic trn);
    for (int i = 0; i < n; i++) begin
      int t;
      s_valid = 1'b1;
      s_data  = 16'(i);
      s_last  = (i == n - 1);
      s_label = lbl;
      s_train = trn;
      t = 0;
      while (!s_ready && t < 3000) begin
        tick();
        t++;
      end
      if (!s_ready) begin
        timeout("s_ready");
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int t;
    t = 0;
    while (!eng_start && t < 3000) begin
      tick();
      t++;
    end
    if (!eng_start) timeout(name);
  endtask

  // From RUN: done high for 3 cycles, then low; returns in REPORT
  task automatic engine_done(input logic [7:0] pred);
    eng_output_idx = pred;
    eng_done = 1'b1;
    tick();
    tick();
    tick();
    eng_done = 1'b0;
    tick();
  endtask

  task automatic ack();
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_start;
    logic stable;

    rd_tab[0] = '{10'd0,    16'd0};
    rd_tab[1] = '{10'd5,    16'd5};
    rd_tab[2] = '{10'd100,  16'd100};
    rd_tab[3] = '{10'd783,  16'd783};
    rd_tab[4] = '{10'd784,  16'd0};
    rd_tab[5] = '{10'd1023, 16'd0};

    // ---- reset state
    tick();
    tick();
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_eng_start", 32'(eng_start), 0);
    check("rst_r_valid", 32'(r_valid), 0);
    check("rst_count", sample_count, 0);
    reset = 1'b1;
    tick();
    check("s_ready_after_release", 32'(s_ready), 1);
    enable = 1'b1;

    // ---- test 1: full sample, launch latency, read port
    send_sample(784, 8'd3, 1'b0);
    check("t1_no_start_yet", 32'(eng_start), 0);
    tick();
    check("t1_start", 32'(eng_start), 1);
    check("t1_train", 32'(eng_train), 0);
    check("t1_expected_out", 32'(expected_out), 3);
    check("t1_err_len", 32'(err_len), 0);
    tick();
    check("t1_start_single", 32'(eng_start), 0);
    for (int i = 0; i < 6; i++) begin
      mem_address = rd_tab[i].addr;
      #1;
      check($sformatf("t1_mem_rd_%0d", rd_tab[i].addr), 32'(mem_input), 32'(rd_tab[i].exp_data));
    end
    mem_address = '0;

    // ---- test 2: result record and statistics
    engine_done(8'd3);
    check("t2_r_valid", 32'(r_valid), 1);
    check("t2_r_pred", 32'(r_pred), 3);
    check("t2_r_label", 32'(r_label), 3);
    check("t2_r_correct", 32'(r_correct), 1);
    check("t2_window", 32'(window_correct), 1);
    check("t2_count", sample_count, 1);
    ack();
    check("t2_r_valid_clr", 32'(r_valid), 0);

    // ---- test 3: two back-to-back samples, both banks full
    send_sample(784, 8'd1, 1'b1);
    send_sample(784, 8'd2, 1'b0);
    check("t3_s_ready_low", 32'(s_ready), 0);
    check("t3_train_held", 32'(eng_train), 1);
    check("t3_expected_out", 32'(expected_out), 1);
    eng_output_idx = 8'd5;
    eng_done = 1'b1;
    tick();
    tick();
    tick();
    eng_done = 1'b0;
    check("t3_s_ready_in_drain", 32'(s_ready), 0);
    tick();
    check("t3_s_ready_rises", 32'(s_ready), 1);
    check("t3_r_pred", 32'(r_pred), 5);
    check("t3_r_correct", 32'(r_correct), 0);
    check("t3_train_drop", 32'(eng_train), 0);
    check("t3_window", 32'(window_correct), 1);

    // ---- test 4: backpressure on result blocks the next launch
    saw_start = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (eng_start) saw_start = 1'b1;
      if (!r_valid || r_pred != 8'd5 || r_label != 8'd1) stable = 1'b0;
    end
    check("t4_no_launch", 32'(saw_start), 0);
    check("t4_record_stable", 32'(stable), 1);
    ack();
    check("t4_idle_no_start", 32'(eng_start), 0);
    tick();
    check("t4_launch", 32'(eng_start), 1);
    check("t4_expected_out", 32'(expected_out), 2);
    tick();
    engine_done(8'd2);
    check("t4_r_correct", 32'(r_correct), 1);
    check("t4_window", 32'(window_correct), 2);
    check("t4_count", sample_count, 3);
    ack();

    // ---- test 5: short sample, then window roll-over
    send_sample(101, 8'd7, 1'b0);
    check("t5_err_len", 32'(err_len), 1);
    wait_start("t5_start");
    check("t5_expected_out", 32'(expected_out), 7);
    tick();
    engine_done(8'd0);
    check("t5_r_valid", 32'(r_valid), 1);
    check("t5_r_label", 32'(r_label), 7);
    ack();
    for (int k = 0; k < 65; k++) begin
      send_sample(2, 8'd9, 1'b0);
      wait_start("t5_loop_start");
      tick();
      engine_done((k == 0) ? 8'd9 : 8'd1);
      if (k == 0)  check("t5_window_first", 32'(window_correct), 3);
      if (k == 63) check("t5_window_64th", 32'(window_correct), 1);
      if (k == 64) check("t5_window_65th", 32'(window_correct), 0);
      ack();
    end
    check("t5_count", sample_count, 69);
    check("t5_err_sticky", 32'(err_len), 1);

    // ---- test 6: reset during RUN
    send_sample(784, 8'd4, 1'b1);
    wait_start("t6_start");
    tick();
    check("t6_train_in_run", 32'(eng_train), 1);
    reset = 1'b0;
    #1;
    check("t6_eng_train", 32'(eng_train), 0);
    check("t6_eng_start", 32'(eng_start), 0);
    check("t6_expected_out", 32'(expected_out), 0);
    check("t6_window", 32'(window_correct), 0);
    check("t6_count", sample_count, 0);
    check("t6_err_len", 32'(err_len), 0);
    check("t6_s_ready", 32'(s_ready), 0);
    tick();
    reset = 1'b1;
    tick();
    check("t6_s_ready_release", 32'(s_ready), 1);
    saw_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (eng_start) saw_start = 1'b1;
    end
    check("t6_banks_empty", 32'(saw_start), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trainer_sample_driver.md
Name: trainer_sample_driver

Overview:
- Host-side counterpart of the online training engine wrapper.
- Accepts pixel samples and labels from a host stream into a ping-pong sample buffer, then serves pixels back on the engine's mem_address/mem_input read port.
- Drives the engine start/train/expected_out, captures the predicted class after done, returns a per-sample result record, and keeps a sliding-window accuracy count for concept-drift monitoring.

Parameters:
- SAMPLE_LEN, 784, pixels per sample; one per engine batch index.
- PIX_W, 16, pixel width in Q8.8.
- ADDR_W, 10, engine memory address width.
- IDX_W, 8, label and predicted-index width.
- WINDOW, 64, number of most recent samples in the accuracy window; power of two, ≤256.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-low; clears all state.
- enable  in  1  permits launching new engine runs.
- s_valid  in  1  host pixel beat valid.
- s_ready  out  1  buffer can accept a beat.
- s_data  in  PIX_W  pixel value.
- s_last  in  1  final pixel of the sample.
- s_label  in  IDX_W  expected class; sampled on the s_last beat.
- s_train  in  1  train-on-this-sample flag; sampled on the s_last beat.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_train  out  1  engine train input; held for the whole run.
- eng_done  in  1  engine done; high for 3 consecutive cycles.
- eng_output_idx  in  IDX_W  registered predicted class from the engine.
- expected_out  out  IDX_W  label of the running sample.
- mem_address  in  ADDR_W  engine pixel read address.
- mem_input  out  PIX_W  pixel at mem_address in the running bank.
- r_valid  out  1  result record valid.
- r_ready  in  1  result consumer ready.
- r_pred  out  IDX_W  captured prediction.
- r_label  out  IDX_W  label of the same sample.
- r_correct  out  1  r_pred == r_label.
- window_correct  out  9  correct predictions among the last min(count, WINDOW) samples.
- sample_count  out  32  results completed since reset; saturates at all-ones.
- err_len  out  1  sticky sample-length error.

Behaviour:
- Reset values: all outputs 0 (s_ready = 1 one cycle after reset release); both banks empty; fill_bank = run_bank = 0; window history cleared.
- Buffer: two banks of SAMPLE_LEN x PIX_W, each with a full flag, a stored label and a stored train bit.
- Write side:
  - s_ready = !full[fill_bank].
  - A beat is accepted on s_valid && s_ready and is written at wr_ptr, which then increments.
  - A sample closes on s_last, or on the beat at wr_ptr == SAMPLE_LEN-1, whichever comes first. On close: full[fill_bank] <= 1, label and train stored, fill_bank toggles, wr_ptr <= 0.
  - If s_last arrives with wr_ptr != SAMPLE_LEN-1, or wr_ptr reaches SAMPLE_LEN-1 without s_last, err_len <= 1 (sticky). The sample is still closed; unwritten pixels keep stale contents.
- Read side: mem_input is a combinational read of bank[run_bank][mem_address]. Addresses ≥ SAMPLE_LEN return 0. expected_out = label[run_bank] while the FSM is outside IDLE, else 0.
- FSM:
  - IDLE: if enable && full[run_bank], go to START.
  - START: eng_start = 1 for exactly this cycle; eng_train <= train[run_bank]; go to RUN.
  - RUN: on eng_done == 1, go to DRAIN.
  - DRAIN: on eng_done == 0, capture r_pred <= eng_output_idx and r_label <= label[run_bank]; full[run_bank] <= 0; run_bank toggles; eng_train <= 0; go to REPORT with r_valid = 1.
  - REPORT: hold the record stable until r_valid && r_ready, then go to IDLE. The next run cannot start before the result is consumed.
- Accuracy window: a WINDOW-bit history shift register updated in the DRAIN-exit cycle. window_correct <= window_correct + r_correct_new - oldest_bit; history bits are 0 until filled. sample_count increments in the same cycle.
- Latency: full flag set to eng_start is 2 cycles (IDLE, START) when enable is high and the FSM is idle.
- Simultaneous events:
  - Host closing a sample into fill_bank in the same cycle the FSM frees run_bank is legal; the banks differ.
  - A host write to the running bank cannot occur, because s_ready is low for a full bank.
  - eng_done while in IDLE, START or REPORT is ignored.
  - Deasserting enable mid-run does not abort the run; it only blocks the next launch.
- Reset mid-operation: all state clears immediately and eng_start/eng_train drop. The engine must be reset in the same event by the integrator.

Test Plan:
1. Reset, then stream 784 beats with s_data = index, label 3, train 0, enable = 1 -> eng_start pulses once 2 cycles after close; mem_address = 5 returns 5; expected_out = 3.
2. Model eng_done high for 3 cycles with eng_output_idx = 3 -> r_valid with r_pred = 3, r_label = 3, r_correct = 1; window_correct = 1; sample_count = 1.
3. Stream two samples back-to-back while the first is running -> s_ready drops after the second closes (both banks full); rises the cycle after DRAIN frees the bank.
4. Hold r_ready = 0 for 10 cycles after a result -> record stable, no new eng_start; launch follows r_ready.
5. Send s_last at beat 100 -> err_len = 1; sample still runs. Then run 65 results, first correct and rest wrong -> window_correct returns to 0 after the 65th.
6. Assert reset (low) during RUN -> all outputs 0, banks empty, s_ready = 1 after release.
